// File: rtl/median_arbiter_if.sv
// Signal bundle between median_arbiter, its pixel-window requesters and the shared median engine.
interface median_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   REQ;
    logic [NREQ*8-1:0] DI_BUS;
    logic [NREQ-1:0]   GNT;
    logic [7:0]        ENG_DI;
    logic              ENG_DSI;
    logic              ENG_NRST;
    logic [7:0]        ENG_DO;
    logic              ENG_DSO;
    logic [7:0]        RES;
    logic              RES_VLD;
    logic [IDW-1:0]    RES_ID;
    logic              TIMEOUT_ERR;
    logic              BUSY;

    modport master (
        input  REQ, DI_BUS, ENG_DO, ENG_DSO,
        output GNT, ENG_DI, ENG_DSI, ENG_NRST, RES, RES_VLD, RES_ID, TIMEOUT_ERR, BUSY
    );

    modport slave (
        output REQ, DI_BUS, ENG_DO, ENG_DSO,
        input  GNT, ENG_DI, ENG_DSI, ENG_NRST, RES, RES_VLD, RES_ID, TIMEOUT_ERR, BUSY
    );
endinterface

// File: rtl/median_arbiter.sv
// Round-robin sequencer sharing one 3x3 median engine among NREQ requesters,
// with result tagging and engine recovery on a missing result strobe.
module median_arbiter #(
    parameter int NREQ    = 4,
    parameter int NPIX    = 9,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             reset,
    median_arbiter_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [IDW-1:0]  win_r, win_s, last_r, last_s, pick_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [7:0]      tmo_r, tmo_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [7:0]      eng_di_r, eng_di_s, lane_s;
    logic            eng_dsi_r, eng_dsi_s;
    logic            eng_nrst_r, eng_nrst_s;
    logic [7:0]      res_r, res_s;
    logic [IDW-1:0]  res_id_r, res_id_s;
    logic            res_vld_r, res_vld_s;
    logic            tmo_err_r, tmo_err_s;
    logic            busy_r, busy_s;

    // First requester after 'last' in circular order; the descending scan leaves the nearest one.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx  = int'(last) + i;
            idx  = (idx >= NREQ) ? idx - NREQ : idx;
            pick = req[idx] ? IDW'(idx) : pick;
        end
        return pick;
    endfunction

    // Next-state and next-output logic for the IDLE/STREAM/WAIT sequencer.
    always_comb begin
        state_s    = state_r;
        win_s      = win_r;
        cnt_s      = cnt_r;
        tmo_s      = tmo_r;
        last_s     = last_r;
        gnt_s      = gnt_r;
        eng_di_s   = eng_di_r;
        eng_dsi_s  = 1'b0;
        eng_nrst_s = 1'b1;
        res_s      = res_r;
        res_id_s   = res_id_r;
        res_vld_s  = 1'b0;
        tmo_err_s  = 1'b0;
        pick_s     = rr_pick(bus.REQ, last_r);
        lane_s     = bus.DI_BUS[int'(win_r)*8 +: 8];
        case (state_r)
            IDLE: begin
                if (|bus.REQ) begin
                    win_s         = pick_s;
                    cnt_s         = '0;
                    gnt_s         = '0;
                    gnt_s[pick_s] = 1'b1;
                    state_s       = STREAM;
                end else begin
                    gnt_s = '0;
                end
            end
            STREAM: begin
                eng_di_s  = lane_s;
                eng_dsi_s = 1'b1;
                if (cnt_r == CW'(NPIX - 1)) begin
                    state_s = WAIT;
                    tmo_s   = 8'd0;
                    gnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            WAIT: begin
                tmo_s = tmo_r + 8'd1;
                // A result strobe on the timeout cycle still counts as a valid result.
                if (bus.ENG_DSO) begin
                    res_s     = bus.ENG_DO;
                    res_id_s  = win_r;
                    res_vld_s = 1'b1;
                    last_s    = win_r;
                    state_s   = IDLE;
                end else if (tmo_r == 8'(TIMEOUT - 1)) begin
                    tmo_err_s  = 1'b1;
                    eng_nrst_s = 1'b0;
                    last_s     = win_r;
                    state_s    = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = '0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset drops the engine's nRST until the first clock edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            win_r      <= '0;
            last_r     <= IDW'(NREQ - 1);
            cnt_r      <= '0;
            tmo_r      <= 8'd0;
            gnt_r      <= '0;
            eng_di_r   <= 8'd0;
            eng_dsi_r  <= 1'b0;
            eng_nrst_r <= 1'b0;
            res_r      <= 8'd0;
            res_id_r   <= '0;
            res_vld_r  <= 1'b0;
            tmo_err_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            win_r      <= win_s;
            last_r     <= last_s;
            cnt_r      <= cnt_s;
            tmo_r      <= tmo_s;
            gnt_r      <= gnt_s;
            eng_di_r   <= eng_di_s;
            eng_dsi_r  <= eng_dsi_s;
            eng_nrst_r <= eng_nrst_s;
            res_r      <= res_s;
            res_id_r   <= res_id_s;
            res_vld_r  <= res_vld_s;
            tmo_err_r  <= tmo_err_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.GNT         = gnt_r;
    assign bus.ENG_DI      = eng_di_r;
    assign bus.ENG_DSI     = eng_dsi_r;
    assign bus.ENG_NRST    = eng_nrst_r;
    assign bus.RES         = res_r;
    assign bus.RES_VLD     = res_vld_r;
    assign bus.RES_ID      = res_id_r;
    assign bus.TIMEOUT_ERR = tmo_err_r;
    assign bus.BUSY        = busy_r;
endmodule

// File: tb/tb_median_arbiter.sv
// Scoreboard bench for median_arbiter: behavioural median engine, pixel-driving requesters,
// and a monitor that pops expected grants/results as the DUT presents them.
module tb_median_arbiter;
    typedef struct {
        bit to;
        int id;
        int res;
        int lat;
    } exp_t;

    logic CLK;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   grant_starts = 0;
    int   gnt_rise_cyc = 0;
    int   gnt_fall_cyc = 0;
    int   eng_delay = 3;
    bit   eng_never = 1'b0;
    bit   stray_req = 1'b0;
    exp_t sbq[$];
    int   gq[$];
    logic [7:0] pix [4][9];
    int   exp_med [4];

    median_arbiter_if #(.NREQ(4)) bus ();

    median_arbiter #(.NREQ(4), .NPIX(9), .TIMEOUT(16)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] median9(input logic [7:0] v [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    // Behavioural engine: collects 9 pixels, answers eng_delay cycles after the last one.
    initial begin : engine
        logic [7:0] ebuf [9];
        int n;
        int wait_cnt;
        n = 0;
        wait_cnt = -1;
        foreach (ebuf[i]) ebuf[i] = 8'd0;
        bus.ENG_DSO = 1'b0;
        bus.ENG_DO  = 8'd0;
        forever begin
            @(posedge CLK);
            if (bus.ENG_DSI === 1'b1 && n < 9) begin
                ebuf[n] = bus.ENG_DI;
                n++;
                if (n == 9) wait_cnt = eng_delay;
            end
            #1;
            bus.ENG_DSO = 1'b0;
            if (wait_cnt == 0) begin
                if (!eng_never) begin
                    bus.ENG_DSO = 1'b1;
                    bus.ENG_DO  = median9(ebuf);
                end
                wait_cnt = -1;
                n = 0;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
            if (stray_req) begin
                bus.ENG_DSO = 1'b1;
                bus.ENG_DO  = 8'd77;
                stray_req   = 1'b0;
            end
            if (!reset || bus.ENG_NRST !== 1'b1) begin
                n = 0;
                wait_cnt = -1;
            end
        end
    end

    // Requesters: pixel k of lane i is driven on the k-th cycle GNT[i] is high.
    initial begin : lanes
        int pc [4];
        logic [31:0] di;
        foreach (pc[i]) pc[i] = 0;
        bus.DI_BUS = '0;
        forever begin
            @(negedge CLK);
            di = bus.DI_BUS;
            for (int i = 0; i < 4; i++) begin
                if (bus.GNT[i] === 1'b1 && pc[i] < 9) begin
                    di[i*8 +: 8] = pix[i][pc[i]];
                    pc[i]++;
                end else if (bus.GNT[i] !== 1'b1) begin
                    pc[i] = 0;
                end
            end
            bus.DI_BUS = di;
        end
    end

    // Monitor: grant order/length, DSI lag/length, and result/timeout scoreboard.
    initial begin : monitor
        logic [3:0] prev_gnt;
        logic       prev_dsi;
        int glen;
        int dlen;
        exp_t e;
        int eg;
        prev_gnt = 4'd0;
        prev_dsi = 1'b0;
        glen = 0;
        dlen = 0;
        forever begin
            @(negedge CLK);
            check($onehot0(bus.GNT), "gnt_onehot", int'(bus.GNT), 0);
            if (bus.GNT != 4'd0 && prev_gnt == 4'd0) begin
                grant_starts++;
                gnt_rise_cyc = cyc;
                glen = 0;
                check(gq.size() != 0, "grant_unexpected", int'(bus.GNT), 0);
                if (gq.size() != 0) begin
                    eg = gq.pop_front();
                    check(bus.GNT == 4'(1 << eg), "grant_id", int'(bus.GNT), 1 << eg);
                end
                check(bus.ENG_NRST === 1'b1, "eng_nrst_at_grant", int'(bus.ENG_NRST), 1);
            end
            if (bus.GNT != 4'd0) glen++;
            if (bus.GNT == 4'd0 && prev_gnt != 4'd0) begin
                gnt_fall_cyc = cyc;
                if (reset) check(glen == 9, "grant_len", glen, 9);
            end
            if (bus.ENG_DSI && !prev_dsi) begin
                dlen = 0;
                check(cyc == gnt_rise_cyc + 1, "dsi_lag", cyc - gnt_rise_cyc, 1);
            end
            if (bus.ENG_DSI) dlen++;
            if (!bus.ENG_DSI && prev_dsi && reset) check(dlen == 9, "dsi_len", dlen, 9);
            if (bus.RES_VLD === 1'b1 || bus.TIMEOUT_ERR === 1'b1) begin
                check(sbq.size() != 0, "unexpected_output", int'({bus.RES_VLD, bus.TIMEOUT_ERR}), 0);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check(bus.TIMEOUT_ERR === e.to, "timeout_flag", int'(bus.TIMEOUT_ERR), int'(e.to));
                    check(bus.RES_VLD === !e.to, "res_vld_flag", int'(bus.RES_VLD), int'(!e.to));
                    check(cyc - gnt_fall_cyc == e.lat, "latency", cyc - gnt_fall_cyc, e.lat);
                    if (!e.to) begin
                        check(int'(bus.RES) == e.res, "res_value", int'(bus.RES), e.res);
                        check(int'(bus.RES_ID) == e.id, "res_id", int'(bus.RES_ID), e.id);
                    end else begin
                        check(bus.ENG_NRST === 1'b0, "eng_nrst_pulse", int'(bus.ENG_NRST), 0);
                    end
                end
            end
            prev_gnt = bus.GNT;
            prev_dsi = bus.ENG_DSI;
        end
    end

    task automatic push_res(input int id, input int lat);
        sbq.push_back('{to: 1'b0, id: id, res: exp_med[id], lat: lat});
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (grant_starts < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(grant_starts >= target, "grant_wait", grant_starts, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.BUSY !== 1'b0 || sbq.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(bus.BUSY === 1'b0 && sbq.size() == 0, "idle_wait", sbq.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check(bus.GNT === 4'd0, {tag, "_gnt"}, int'(bus.GNT), 0);
        check(bus.ENG_DI === 8'd0, {tag, "_eng_di"}, int'(bus.ENG_DI), 0);
        check(bus.ENG_DSI === 1'b0, {tag, "_eng_dsi"}, int'(bus.ENG_DSI), 0);
        check(bus.ENG_NRST === 1'b0, {tag, "_eng_nrst"}, int'(bus.ENG_NRST), 0);
        check(bus.RES === 8'd0, {tag, "_res"}, int'(bus.RES), 0);
        check(bus.RES_VLD === 1'b0, {tag, "_res_vld"}, int'(bus.RES_VLD), 0);
        check(bus.RES_ID === 2'd0, {tag, "_res_id"}, int'(bus.RES_ID), 0);
        check(bus.TIMEOUT_ERR === 1'b0, {tag, "_timeout_err"}, int'(bus.TIMEOUT_ERR), 0);
        check(bus.BUSY === 1'b0, {tag, "_busy"}, int'(bus.BUSY), 0);
    endtask

    initial begin : stim
        int base;
        pix[0] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        pix[1] = '{8'd5, 8'd200, 8'd7, 8'd100, 8'd3, 8'd150, 8'd9, 8'd250, 8'd1};
        pix[2] = '{8'd68, 8'd60, 8'd66, 8'd62, 8'd64, 8'd61, 8'd67, 8'd63, 8'd65};
        pix[3] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
        exp_med = '{50, 9, 64, 128};
        reset = 1'b1;
        bus.REQ = 4'd0;
        #1 reset = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_state("por");
        reset = 1'b1;
        @(negedge CLK);
        check(bus.ENG_NRST === 1'b1, "eng_nrst_rise", int'(bus.ENG_NRST), 1);

        // Fairness from reset: requester 0 first, then strict rotation.
        eng_delay = 3;
        for (int k = 0; k < 8; k++) begin
            gq.push_back(k % 4);
            push_res(k % 4, 5);
        end
        base = grant_starts;
        bus.REQ = 4'b1111;
        wait_grants(base + 8, 400);
        bus.REQ = 4'd0;
        wait_idle(100);

        // Single request with a 12-cycle engine.
        eng_delay = 12;
        gq.push_back(0);
        push_res(0, 14);
        base = grant_starts;
        bus.REQ = 4'b0001;
        wait_grants(base + 1, 50);
        bus.REQ = 4'd0;
        wait_idle(100);

        // Serve 1, then 0011 wraps to 0 before 1.
        eng_delay = 3;
        gq.push_back(1);
        push_res(1, 5);
        base = grant_starts;
        bus.REQ = 4'b0010;
        wait_grants(base + 1, 50);
        bus.REQ = 4'd0;
        wait_idle(100);
        gq.push_back(0);
        gq.push_back(1);
        push_res(0, 5);
        push_res(1, 5);
        base = grant_starts;
        bus.REQ = 4'b0011;
        wait_grants(base + 2, 100);
        bus.REQ = 4'd0;
        wait_idle(100);

        // Engine silent for requester 2: timeout, then requester 3 is served.
        eng_never = 1'b1;
        gq.push_back(2);
        gq.push_back(3);
        sbq.push_back('{to: 1'b1, id: 2, res: 0, lat: 16});
        push_res(3, 5);
        base = grant_starts;
        bus.REQ = 4'b1100;
        wait_grants(base + 2, 100);
        eng_never = 1'b0;
        bus.REQ = 4'd0;
        wait_idle(100);

        // Result strobe on the timeout cycle wins.
        eng_delay = 14;
        gq.push_back(0);
        push_res(0, 16);
        base = grant_starts;
        bus.REQ = 4'b0001;
        wait_grants(base + 1, 50);
        bus.REQ = 4'd0;
        wait_idle(100);

        // Stray result strobe while idle.
        stray_req = 1'b1;
        repeat (4) @(negedge CLK);
        check(bus.RES === 8'd50, "stray_res_hold", int'(bus.RES), 50);
        check(bus.RES_ID === 2'd0, "stray_res_id_hold", int'(bus.RES_ID), 0);

        // REQ dropped mid-burst, then asynchronous reset during WAIT.
        eng_never = 1'b1;
        gq.push_back(2);
        base = grant_starts;
        bus.REQ = 4'b0100;
        wait_grants(base + 1, 50);
        repeat (3) @(negedge CLK);
        bus.REQ = 4'd0;
        repeat (10) @(negedge CLK);
        check(bus.BUSY === 1'b1, "busy_in_wait", int'(bus.BUSY), 1);
        check(bus.GNT === 4'd0, "gnt_off_in_wait", int'(bus.GNT), 0);
        #2 reset = 1'b0;
        #1 check_reset_state("mid_wait");
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        eng_never = 1'b0;
        eng_delay = 3;
        gq.push_back(0);
        push_res(0, 5);
        base = grant_starts;
        bus.REQ = 4'b1111;
        wait_grants(base + 1, 50);
        bus.REQ = 4'd0;
        wait_idle(100);

        check(gq.size() == 0, "grant_queue_drained", gq.size(), 0);
        check(sbq.size() == 0, "result_queue_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/median_arbiter.md
# median_arbiter

Round-robin arbiter and sequencer that shares one 3x3 median engine (the `MEDIAN` top built on the `MED` cell) among `NREQ` pixel-window requesters. It grants the engine to one requester at a time, streams that requester's `NPIX` pixels into the engine, and waits for the engine's result strobe. It then returns the median tagged with the requester index, and recovers the engine if the result never arrives.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NPIX`, 9, pixels per window burst
- `TIMEOUT`, 64, max cycles to wait for engine `DSO` after the last pixel (2..255)

- `CLK`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `REQ`  in  NREQ  request per requester, level
- `DI_BUS`  in  NREQ*8  pixel lane per requester, lane i = bits [8i+7:8i]
- `GNT`  out  NREQ  one-hot grant; requester i drives its next pixel on each granted cycle
- `ENG_DI`  out  8  pixel to engine `DI`
- `ENG_DSI`  out  1  to engine `DSI`
- `ENG_NRST`  out  1  to engine `nRST`
- `ENG_DO`  in  8  engine result
- `ENG_DSO`  in  1  engine result strobe
- `RES`  out  8  median result
- `RES_VLD`  out  1  one-cycle result strobe
- `RES_ID`  out  clog2(NREQ)  requester index of `RES`
- `TIMEOUT_ERR`  out  1  one-cycle pulse on engine timeout
- `BUSY`  out  1  high in any state but IDLE

## Operation
- States: IDLE, STREAM, WAIT.
- Reset: state IDLE; `GNT`, `ENG_DI`, `ENG_DSI`, `RES`, `RES_VLD`, `RES_ID`, `TIMEOUT_ERR`, `BUSY` = 0; `ENG_NRST` = 0; pointer `last` = NREQ-1, so requester 0 has first priority.
- `ENG_NRST` is registered. It rises to 1 on the first edge after reset deasserts.
- IDLE: if any `REQ` bit is set, the winner is the first set bit scanning `last+1, last+2, ...` mod NREQ. Latch `win`, clear `cnt`, go to STREAM. With no request, stay in IDLE.
- STREAM: `GNT[win]` = 1. On each edge:
  - `ENG_DI` <= lane `win`, `ENG_DSI` <= 1, `cnt++`.
  - When `cnt` = NPIX-1, go to WAIT and clear `tmo`.
  - `REQ` deasserting mid-burst is ignored; the burst always completes.
- WAIT: `GNT` = 0, `ENG_DSI` <= 0, `tmo++` each cycle.
  - If `ENG_DSO` = 1: `RES` <= `ENG_DO`, `RES_ID` <= `win`, `RES_VLD` <= 1 for one cycle, `last` <= `win`, go to IDLE.
  - Else if `tmo` = TIMEOUT-1: `TIMEOUT_ERR` <= 1 for one cycle, `ENG_NRST` <= 0 for one cycle, `last` <= `win`, `RES_VLD` stays 0, go to IDLE.
  - `ENG_DSO` and timeout in the same cycle: `ENG_DSO` wins, no error.
- `ENG_DSO` outside WAIT is ignored and does not update `RES`.
- `RES`/`RES_ID` hold their value between strobes.
- Widths: `cnt` is clog2(NPIX) bits; `tmo` is 8 bits; the pointer wraps mod NREQ, including for non-power-of-2 NREQ.

## Timing
- `GNT[win]` is high for exactly NPIX consecutive cycles, starting the cycle after the IDLE cycle in which `REQ` was seen.
- The requester's lane is sampled on each of those NPIX edges. Pixel k must be valid on the k-th granted cycle.
- `ENG_DSI`/`ENG_DI` lag `GNT` by one cycle: `ENG_DSI` is high NPIX cycles, starting 1 cycle after `GNT` rises.
- `RES_VLD` rises 1 cycle after the `ENG_DSO` edge. The next `GNT` rises at the earliest 2 cycles after `ENG_DSO` (one IDLE cycle).
- Timeout: `TIMEOUT_ERR` fires TIMEOUT cycles after entering WAIT.
- `reset` asserted mid-STREAM/WAIT clears everything immediately, asynchronously. No result and no error is reported for the aborted burst.

## Test plan
- Single request: `REQ`=0001, lane0 = 10,20,..,90, engine model returns 50 after 12 cycles -> `GNT`=0001 for 9 cycles; `ENG_DSI` high 9 cycles delayed 1; `RES`=50, `RES_ID`=0, one-cycle `RES_VLD`.
- Fairness: `REQ`=1111 held, 8 bursts -> grant order 0,1,2,3,0,1,2,3; exactly one `GNT` bit ever high.
- Pointer skip: after serving 1, `REQ`=0011 -> next grant is 0 (wrap), then 1.
- Timeout: engine never raises `ENG_DSO`, TIMEOUT=16 -> `TIMEOUT_ERR` pulse 16 cycles after WAIT entry; `ENG_NRST` low one cycle; no `RES_VLD`; next requester granted after it.
- Edge cases:
  - `ENG_DSO` and timeout in the same cycle -> `RES_VLD` only.
  - Stray `ENG_DSO` in IDLE -> `RES` unchanged.
- `REQ` dropped mid-STREAM, then `reset` pulsed mid-WAIT -> burst completes 9 pixels; after reset all outputs 0, state IDLE, requester 0 gets priority.
